// File: rtl/lab4_branch_pht_pkg.sv
// Shared types and helpers for the branch PHT port scheduler.
package lab4_branch_pht_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_UPD_RD = 2'd2,
        ST_UPD_WR = 2'd3
    } pht_state_e;

    // 2-bit saturating counter encodings
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    function automatic logic [1:0] ctr_sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != CTR_ST) res = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/lab4_branch_pht_upd_queue.sv
// Update FIFO holding {index, taken} entries waiting for the shared PHT port.
module lab4_branch_pht_upd_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enq_val,
    output logic                     enq_rdy,
    input  logic [WIDTH-1:0]         enq_data,
    output logic                     deq_val,
    input  logic                     deq_rdy,
    output logic [WIDTH-1:0]         deq_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             push, pop;

    // Full-ness is judged on the start-of-cycle count, so a pop never makes room for a same-cycle push
    assign enq_rdy  = (cnt_q != FULL_CNT);
    assign deq_val  = (cnt_q != '0);
    assign deq_data = mem_q[rd_ptr_q];
    assign count    = cnt_q;
    assign push     = enq_val && enq_rdy;
    assign pop      = deq_val && deq_rdy;

    // Next pointer and occupancy values; pointers wrap naturally at the power-of-two depth
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage; contents need no reset since count gates validity
    always_ff @(posedge clk) begin
        if (push && !reset) mem_q[wr_ptr_q] <= enq_data;
    end

endmodule

// File: rtl/lab4_branch_pht_scheduler.sv
// Sequences one shared PHT port between init sweep, lookups and queued counter updates.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_INIT   | sweep every PHT entry to weakly-not-taken, one per cycle
// ST_IDLE   | serve lookups; decide whether the head update takes the port
// ST_UPD_RD | read the counter at the head update's index
// ST_UPD_WR | write the saturated counter back and pop the head update
module lab4_branch_pht_scheduler
    import lab4_branch_pht_pkg::*;
#(
    parameter int PHT_SIZE = 2048,
    parameter int UQ_DEPTH = 4,
    localparam int IDX_NBITS = $clog2(PHT_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 lk_val,
    output logic                 lk_rdy,
    input  logic [31:0]          lk_pc,
    output logic                 pred_val,
    output logic                 pred_taken,
    input  logic                 up_val,
    output logic                 up_rdy,
    input  logic [31:0]          up_pc,
    input  logic                 up_taken,
    output logic [IDX_NBITS-1:0] pht_addr,
    input  logic [1:0]           pht_rdata,
    output logic                 pht_wen,
    output logic [1:0]           pht_wdata
);

    localparam int QW    = IDX_NBITS + 1;
    localparam int CNT_W = $clog2(UQ_DEPTH) + 1;
    localparam logic [CNT_W-1:0]     Q_FULL    = CNT_W'(UQ_DEPTH);
    localparam logic [IDX_NBITS-1:0] INIT_LAST = IDX_NBITS'(PHT_SIZE - 1);

    pht_state_e           state_q, state_d;
    logic [IDX_NBITS-1:0] init_cnt_q, init_cnt_d;
    logic [1:0]           rd_ctr_q, rd_ctr_d;
    logic                 pred_val_q, pred_val_d;
    logic                 pred_taken_q, pred_taken_d;

    logic                 q_enq_rdy, q_deq_val, q_deq_rdy;
    logic [QW-1:0]        q_deq_data;
    logic [CNT_W-1:0]     q_count, q_occ;
    logic [IDX_NBITS-1:0] lk_idx, up_idx, head_idx;
    logic                 head_taken, upd_grant, lk_fire;
    logic                 unused_pc_bits;

    assign lk_idx     = lk_pc[IDX_NBITS+1:2];
    assign up_idx     = up_pc[IDX_NBITS+1:2];
    assign head_idx   = q_deq_data[QW-1:1];
    assign head_taken = q_deq_data[0];
    assign unused_pc_bits = ^{lk_pc[31:IDX_NBITS+2], lk_pc[1:0],
                              up_pc[31:IDX_NBITS+2], up_pc[1:0], q_deq_val};

    lab4_branch_pht_upd_queue #(
        .DEPTH (UQ_DEPTH),
        .WIDTH (QW)
    ) u_upd_queue (
        .clk      (clk),
        .reset    (reset),
        .enq_val  (up_val),
        .enq_rdy  (q_enq_rdy),
        .enq_data ({up_idx, up_taken}),
        .deq_val  (q_deq_val),
        .deq_rdy  (q_deq_rdy),
        .deq_data (q_deq_data),
        .count    (q_count)
    );

    assign up_rdy = q_enq_rdy && !reset;

    // Occupancy counts an update enqueued this cycle, so an update arriving at an
    // idle, empty queue is granted at once and its read lands in the next cycle.
    assign q_occ     = q_count + CNT_W'(up_val && up_rdy);
    assign upd_grant = (state_q == ST_IDLE) &&
                       ((q_occ == Q_FULL) || ((q_occ != '0) && !lk_val));
    assign lk_rdy    = (state_q == ST_IDLE) && !upd_grant && !reset;
    assign lk_fire   = lk_val && lk_rdy;

    assign pred_val   = pred_val_q && !reset;
    assign pred_taken = pred_taken_q;

    // Port mux, next-state and prediction capture
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        rd_ctr_d     = rd_ctr_q;
        pred_val_d   = lk_fire;
        pred_taken_d = pred_taken_q;
        pht_addr     = lk_idx;
        pht_wen      = 1'b0;
        pht_wdata    = CTR_WNT;
        q_deq_rdy    = 1'b0;
        case (state_q)
            ST_INIT: begin
                pht_addr   = init_cnt_q;
                pht_wen    = 1'b1;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == INIT_LAST) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (lk_fire)   pred_taken_d = pht_rdata[1];
                if (upd_grant) state_d      = ST_UPD_RD;
            end
            ST_UPD_RD: begin
                pht_addr = head_idx;
                rd_ctr_d = pht_rdata;
                state_d  = ST_UPD_WR;
            end
            ST_UPD_WR: begin
                pht_addr  = head_idx;
                pht_wen   = 1'b1;
                pht_wdata = ctr_sat_update(rd_ctr_q, head_taken);
                q_deq_rdy = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
        // A reset cycle abandons any in-flight update without touching the PHT
        if (reset) begin
            pht_wen   = 1'b0;
            q_deq_rdy = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            rd_ctr_q     <= CTR_SNT;
            pred_val_q   <= 1'b0;
            pred_taken_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            rd_ctr_q     <= rd_ctr_d;
            pred_val_q   <= pred_val_d;
            pred_taken_q <= pred_taken_d;
        end
    end

endmodule
